// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet arbiters (state encoding, id width).
package axis_arb_pkg;

   function automatic int CH_ID_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/axis_packet_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N. Shared by the packet, DMA and trigger arbiters.
module rr_priority_select
   import axis_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = CH_ID_W(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          found_o,
   output logic [IW-1:0] index_o
);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   // Walk from the farthest offset down so the nearest request wins last.
   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      sum     = '0;
      idx     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_i} + (IW + 1)'(k);
         if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
         end
         idx = sum[IW-1:0];
         if (req_i[idx]) begin
            found_o = 1'b1;
            index_o = idx;
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: one registered AXI-stream output shared by
// N_CH requesters, grant held from first beat to last, beats tagged with source.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int DWIDTH = 192,
   localparam int IW    = CH_ID_W(N_CH)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [N_CH-1:0][DWIDTH-1:0]  sData_i,
   input  logic [N_CH-1:0]              sValid_i,
   input  logic [N_CH-1:0]              sLast_i,
   output logic [N_CH-1:0]              sReady_o,
   output logic [DWIDTH-1:0]            mData_o,
   output logic                         mValid_o,
   output logic                         mLast_o,
   input  logic                         mReady_i,
   input  logic [N_CH-1:0]              channelEnable_i,
   output logic [IW-1:0]                channelId_o,
   output logic                         busy_o
);

   arb_state_t        state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     lastGrant_q, lastGrant_d;
   logic [IW-1:0]     ptr;
   logic [N_CH-1:0]   req;
   logic              found;
   logic [IW-1:0]     foundIdx;
   logic              stageReady;
   logic              selValid;
   logic              selLast;
   logic [DWIDTH-1:0] selData;
   logic              accept;

   logic [DWIDTH-1:0] mData_q;
   logic              mValid_q;
   logic              mLast_q;
   logic [IW-1:0]     channelId_q;

   assign req        = sValid_i & channelEnable_i;
   assign stageReady = !mValid_q || mReady_i;
   assign selValid   = sValid_i[grant_q];
   assign selLast    = sLast_i[grant_q];
   assign selData    = sData_i[grant_q];
   assign accept     = (state_q == LOCKED) && stageReady && selValid;

   always_comb begin
      if (lastGrant_q == IW'(N_CH - 1)) begin
         ptr = '0;
      end else begin
         ptr = lastGrant_q + 1'b1;
      end
   end

   rr_priority_select #(
      .N  (N_CH),
      .IW (IW)
   ) u_select (
      .req_i   (req),
      .ptr_i   (ptr),
      .found_o (found),
      .index_o (foundIdx)
   );

   // Ready depends only on registered state and mReady_i, never on any valid.
   always_comb begin
      sReady_o = '0;
      if (state_q == LOCKED) begin
         sReady_o[grant_q] = stageReady;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = foundIdx;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (accept && selLast) begin
               lastGrant_d = grant_q;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         lastGrant_q <= IW'(N_CH - 1);
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Output stage advances only when it is empty or being drained.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mValid_q    <= 1'b0;
         mLast_q     <= 1'b0;
         mData_q     <= '0;
         channelId_q <= '0;
      end else if (stageReady) begin
         mValid_q <= accept;
         if (accept) begin
            mData_q     <= selData;
            mLast_q     <= selLast;
            channelId_q <= grant_q;
         end
      end
   end

   assign mData_o     = mData_q;
   assign mValid_o    = mValid_q;
   assign mLast_o     = mLast_q;
   assign channelId_o = channelId_q;
   assign busy_o      = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: randomized packets and backpressure
// scored against a packet-level round-robin model.
module tb_axis_packet_arbiter;

   localparam int NCH = 4;
   localparam int DW  = 192;
   localparam int IW  = $clog2(NCH);

   typedef struct packed {
      logic [IW-1:0] ch;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic                    clk;
   logic                    rstN;
   logic [NCH-1:0][DW-1:0]  sData;
   logic [NCH-1:0]          sValid;
   logic [NCH-1:0]          sLast;
   logic [NCH-1:0]          sReady;
   logic [DW-1:0]           mData;
   logic                    mValid;
   logic                    mLast;
   logic                    mReady;
   logic [NCH-1:0]          channelEnable;
   logic [IW-1:0]           channelId;
   logic                    busy;

   axis_packet_arbiter #(
      .N_CH   (NCH),
      .DWIDTH (DW)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .sData_i         (sData),
      .sValid_i        (sValid),
      .sLast_i         (sLast),
      .sReady_o        (sReady),
      .mData_o         (mData),
      .mValid_o        (mValid),
      .mLast_o         (mLast),
      .mReady_i        (mReady),
      .channelEnable_i (channelEnable),
      .channelId_o     (channelId),
      .busy_o          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   logic [DW:0] srcQ   [NCH][$];
   logic [DW:0] modelQ [NCH][$];
   beat_t       expQ[$];
   int          modelLastG;
   int          readyPct;
   int          stepCount;
   int          firstValidStep;
   int          lastOutStep;
   int          outBeats;
   int          seqNo;
   logic [NCH-1:0] lastHsIn;
   logic        prevStall;
   logic [DW-1:0] prevData;
   logic        prevLast;
   logic [IW-1:0] prevId;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic loadPacket(input int c, input int len);
      logic [DW:0] b;
      for (int i = 0; i < len; i++) begin
         b = {(i == len - 1), $urandom, $urandom, $urandom, $urandom, $urandom,
              8'(c), 8'(seqNo), 16'(i)};
         srcQ[c].push_back(b);
         modelQ[c].push_back(b);
      end
      seqNo++;
   endtask

   task automatic movePacket(input int c);
      logic [DW:0] b;
      beat_t       e;
      do begin
         b = modelQ[c].pop_front();
         e.ch   = IW'(c);
         e.last = b[DW];
         e.data = b[DW-1:0];
         expQ.push_back(e);
      end while (!b[DW]);
   endtask

   // Model: whole packets leave in round-robin order after the last winner.
   task automatic buildOrder(input logic [NCH-1:0] mask);
      bit found;
      do begin
         found = 1'b0;
         for (int k = 1; k <= NCH && !found; k++) begin
            int c;
            c = (modelLastG + k) % NCH;
            if (mask[c] && modelQ[c].size() > 0) begin
               found = 1'b1;
               movePacket(c);
               modelLastG = c;
            end
         end
      end while (found);
   endtask

   task automatic applyStimulus();
      for (int c = 0; c < NCH; c++) begin
         if (srcQ[c].size() > 0) begin
            sValid[c] = 1'b1;
            {sLast[c], sData[c]} = srcQ[c][0];
         end else begin
            sValid[c] = 1'b0;
            sLast[c]  = 1'b0;
            sData[c]  = '0;
         end
      end
      mReady = ($urandom_range(99) < readyPct);
   endtask

   task automatic checkOutput();
      logic  hsOut;
      beat_t e;
      lastHsIn = sValid & sReady;
      hsOut    = mValid & mReady;
      check("oneReady", 256'($countones(sReady) <= 1), 256'(1));
      if (!busy) check("idleReady", 256'(sReady), 256'(0));
      if (prevStall) begin
         check("holdValid", 256'(mValid), 256'(1));
         check("holdData", 256'(mData), 256'(prevData));
         check("holdLast", 256'(mLast), 256'(prevLast));
         check("holdId", 256'(channelId), 256'(prevId));
      end
      if (mValid && firstValidStep < 0) firstValidStep = stepCount;
      if (hsOut) begin
         lastOutStep = stepCount;
         outBeats++;
         check("beatExpected", 256'(expQ.size() > 0), 256'(1));
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("beatCh", 256'(channelId), 256'(e.ch));
            check("beatLast", 256'(mLast), 256'(e.last));
            check("beatData", 256'(mData), 256'(e.data));
         end
      end
      prevStall = mValid & !mReady;
      prevData  = mData;
      prevLast  = mLast;
      prevId    = channelId;
   endtask

   task automatic step();
      applyStimulus();
      #2;
      checkOutput();
      @(posedge clk);
      for (int c = 0; c < NCH; c++) begin
         if (lastHsIn[c]) void'(srcQ[c].pop_front());
      end
      stepCount++;
      @(negedge clk);
   endtask

   task automatic runDrain(input int maxSteps);
      int n;
      n = 0;
      while (expQ.size() > 0 && n < maxSteps) begin
         step();
         n++;
      end
      check("drained", 256'(expQ.size()), 256'(0));
   endtask

   task automatic doReset();
      rstN = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         srcQ[c].delete();
         modelQ[c].delete();
      end
      expQ.delete();
      sValid = '0;
      sLast  = '0;
      sData  = '0;
      modelLastG     = NCH - 1;
      prevStall      = 1'b0;
      firstValidStep = -1;
      lastOutStep    = -1;
      outBeats       = 0;
      lastHsIn       = '0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      int loadStep;
      int n;
      rstN = 1'b0;
      sValid = '0;
      sLast = '0;
      sData = '0;
      mReady = 1'b0;
      channelEnable = '0;
      readyPct = 100;
      stepCount = 0;
      seqNo = 0;
      #1;
      check("rstValid", 256'(mValid), 256'(0));
      check("rstLast", 256'(mLast), 256'(0));
      check("rstData", 256'(mData), 256'(0));
      check("rstId", 256'(channelId), 256'(0));
      check("rstBusy", 256'(busy), 256'(0));
      check("rstReady", 256'(sReady), 256'(0));
      @(negedge clk);

      // Single enabled channel, 4-beat packet, first beat two cycles after valid.
      doReset();
      channelEnable = 4'b0010;
      readyPct = 100;
      loadPacket(1, 4);
      buildOrder(channelEnable);
      loadStep = stepCount;
      runDrain(40);
      check("firstLatency", 256'(firstValidStep - loadStep), 256'(2));
      check("t1Beats", 256'(outBeats), 256'(4));

      // All channels, 2-beat packets, continuous: one bubble between packets.
      doReset();
      channelEnable = 4'b1111;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NCH; c++) loadPacket(c, 2);
      buildOrder(channelEnable);
      runDrain(100);
      check("rrSpan", 256'(lastOutStep - firstValidStep), 256'(22));
      check("t2Beats", 256'(outBeats), 256'(16));

      // 16-beat packet under 50% backpressure.
      doReset();
      readyPct = 50;
      loadPacket(2, 16);
      buildOrder(channelEnable);
      runDrain(400);
      check("t3Beats", 256'(outBeats), 256'(16));

      // Enable of ch1 cleared mid-packet: packet completes, ch1 then skipped.
      doReset();
      readyPct = 70;
      channelEnable = 4'b0111;
      loadPacket(1, 8);
      buildOrder(channelEnable);
      n = 0;
      while (!lastHsIn[1] && n < 50) begin
         step();
         n++;
      end
      check("ch1Started", 256'(lastHsIn[1]), 256'(1));
      channelEnable = 4'b0101;
      loadPacket(0, 2);
      loadPacket(2, 3);
      loadPacket(1, 2);
      loadPacket(0, 1);
      loadPacket(2, 2);
      buildOrder(channelEnable);
      runDrain(300);
      n = outBeats;
      repeat (10) step();
      check("ch1Skipped", 256'(outBeats), 256'(n));
      check("ch1IdleBusy", 256'(busy), 256'(0));

      // Single-beat packets alternate between ch0 and ch3.
      doReset();
      readyPct = 100;
      channelEnable = 4'b1111;
      for (int r = 0; r < 3; r++) begin
         loadPacket(0, 1);
         loadPacket(3, 1);
      end
      buildOrder(channelEnable);
      runDrain(60);
      check("t5Beats", 256'(outBeats), 256'(6));

      // Random packets, lengths, enable mask and backpressure.
      doReset();
      readyPct = 60;
      channelEnable = 4'($urandom_range(15)) | 4'b0001;
      for (int c = 0; c < NCH; c++) begin
         int np;
         np = $urandom_range(3, 1);
         for (int p = 0; p < np; p++) loadPacket(c, $urandom_range(5, 1));
      end
      buildOrder(channelEnable);
      runDrain(1000);

      // Reset during beat 3 of a 6-beat packet.
      doReset();
      readyPct = 100;
      channelEnable = 4'b1111;
      loadPacket(1, 6);
      buildOrder(channelEnable);
      n = 0;
      while (outBeats < 2 && n < 40) begin
         step();
         n++;
      end
      check("beat3Present", 256'(mValid), 256'(1));
      check("beat3Data", 256'(mData), 256'(expQ[0].data));
      rstN = 1'b0;
      #1;
      check("midRstValid", 256'(mValid), 256'(0));
      check("midRstBusy", 256'(busy), 256'(0));
      check("midRstId", 256'(channelId), 256'(0));
      doReset();
      loadPacket(2, 2);
      loadPacket(3, 3);
      loadPacket(0, 2);
      buildOrder(channelEnable);
      check("modelCh0First", 256'(expQ[0].ch), 256'(0));
      runDrain(60);
      check("t6Beats", 256'(outBeats), 256'(7));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-level round-robin arbiter that shares one `Axis_If` datapath (normally the input of `axis_width_converter`) between `N_CH` requesting streams. A grant is held from the first beat of a packet until the beat carrying `last`, so packets are never interleaved. The output is registered and tagged with the source channel index, so downstream logic can route or label the resized words.

## Interface
- `N_CH`, 4: number of requesting streams; legal range 2..16.
- `DWIDTH`, 192: data width of every input and of the output.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-low; asserted when 0.
- `data_in[N_CH]`  `Axis_If.Slave_Full`  DWIDTH  requester streams (data/valid/ready/last).
- `data_out`  `Axis_If.Master_Full`  DWIDTH  arbitrated stream to the shared datapath.
- `channel_enable`  in  N_CH  per-channel grant mask; 1 = channel may win arbitration.
- `channel_id`  out  $clog2(N_CH)  source index of the current `data_out` beat; valid when `data_out.valid`.
- `busy`  out  1  high while a grant is held (state LOCKED).

## Operation
- States: IDLE (no grant) and LOCKED (grant `g` held).
- IDLE: each cycle, search channels `ptr, ptr+1, … ptr+N_CH-1` (mod N_CH), where `ptr = last_grant+1 mod N_CH`. Pick the first channel with `data_in[i].valid & channel_enable[i]`. If one is found, register `g <= i` and go to LOCKED. Otherwise stay in IDLE. All `data_in[*].ready` are 0 in IDLE.
- LOCKED:
  - `data_in[g].ready = stage_ready`, where `stage_ready = !data_out.valid | data_out.ready`. All other ready signals are 0.
  - On `data_in[g].ok` the output register loads data, last and `g`.
  - If the accepted beat has `last=1`: `last_grant <= g`, go to IDLE.
- Output register: when `stage_ready`, load `data_out.valid <= data_in[g].ok`. If not `stage_ready`, hold everything.
- `channel_enable` is sampled only in IDLE. Deasserting the enable of a locked channel takes effect after its `last`.
- A packet of length 1 (`valid & last` on the first beat) is legal: LOCKED lasts exactly one accepted beat.
- Reset values: state IDLE, `last_grant = N_CH-1` (channel 0 wins first), `g = 0`, `data_out.valid = 0`, `data_out.last = 0`, `data_out.data = 0`, `channel_id = 0`, `busy = 0`.
- Reset mid-packet: the in-flight packet is abandoned and the output beat is dropped. The downstream converter must be reset together with this block.

## Timing
- Arbitration latency: request `valid` seen in IDLE at cycle n → grant registered at n+1 → first beat accepted at n+1 at the earliest → appears on `data_out` at n+2.
- Accepted beat to `data_out` latency: 1 cycle.
- Full throughput inside a packet: 1 beat/cycle while `data_out.ready=1`.
- Packet-to-packet gap: exactly one IDLE cycle, so the output carries 1 bubble per packet.
- No combinational path from `data_in[*].valid` to any `data_in[*].ready`. `data_out.ready` reaches `data_in[g].ready` combinationally through `stage_ready` only.
- Asynchronous reset clears outputs immediately. Deassertion is synchronized externally.

## Structure
- Shared package `axis_arb_pkg`:
  - `CH_ID_W(N)` function, returning $clog2(N).
  - `arb_state_t` enum {IDLE, LOCKED}.
- Sub-module `rr_priority_select #(N)`: combinational. Inputs are the request vector (valid & enable) and `ptr`. Outputs are `found` and a binary `index`. It is reusable by later DMA and trigger arbiters.
- Top level holds the FSM, `g`, `last_grant`, the ready demux, the input mux and the output register.

## Test plan
- Single channel 1 enabled, 4-beat packet, `data_out.ready=1` → 4 output beats, `channel_id=1`, `last` on beat 4 only; first beat 2 cycles after valid.
- Channels 0,1,2,3 all valid with 2-beat packets, continuous → output order 0,1,2,3,0… with one bubble between packets and no interleaving.
- Random `data_out.ready` backpressure (50%) on a 16-beat packet from ch 2 → all 16 beats delivered in order, no duplicates. Data is held stable while `valid & !ready`.
- `channel_enable[1]` cleared mid-packet of ch 1 → packet completes. Ch 1 is then skipped while ch 0 and ch 2 continue round-robin.
- Single-beat packets (`last=1` every beat) on ch 0 and ch 3 → grants alternate 0,3,0,3, each beat with `last=1`.
- Reset asserted (0) during beat 3 of a 6-beat packet → `data_out.valid` drops to 0 immediately. After release, ch 0 wins first regardless of pending requests.
